// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and helpers for the data-memory access controller.
// Holds the DMCtrl encoding, the FSM state type and the per-request size/legality helpers.
package dmem_pkg;

    typedef enum logic [2:0] {
        DM_B  = 3'b000,
        DM_H  = 3'b001,
        DM_W  = 3'b010,
        DM_BU = 3'b100,
        DM_HU = 3'b101
    } dmctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dmem_state_t;

    function automatic logic [2:0] access_bytes(input dmctrl_t c);
        case (c)
            DM_H, DM_HU: return 3'd2;
            DM_W:        return 3'd4;
            default:     return 3'd1;
        endcase
    endfunction

    function automatic logic ctrl_legal(input logic [2:0] c);
        case (c)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; on a conflict the port not granted last time wins.
// last_grant resets to 1 so port 0 wins the first conflict.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        gnt          = 2'b00;
        last_grant_d = last_grant_q;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
            if (gnt[0]) begin
                last_grant_d = 1'b0;
            end else if (gnt[1]) begin
                last_grant_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Two-port grant/access/response controller in front of the RV32I data memory.
// Optional macro DMEM_ACCESS_ALIGN_CHECK_EN adds misaligned half/word rejection to the bad check.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_i,
    input  logic [31:0] addr_i  [2],
    input  logic [31:0] wdata_i [2],
    input  logic [1:0]  wr_i,
    input  logic [2:0]  ctrl_i  [2],
    output logic [1:0]  gnt_o,
    output logic [1:0]  rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_wr_o,
    output logic [2:0]  mem_ctrl_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_SIZE);

    dmem_state_t state_q, state_d;
    logic        port_q,  port_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q,    wr_d;
    logic [2:0]  ctrl_q,  ctrl_d;
    logic        bad_q,   bad_d;
    logic [31:0] rdata_q, rdata_d;

    logic        arb_en;
    logic [1:0]  gnt;
    logic        sel;
    logic [31:0] sel_addr;
    logic [2:0]  sel_ctrl;
    logic [32:0] last_byte;
    logic        misalign;
    logic        sel_bad;

    assign arb_en = (state_q == ST_IDLE) && !rst;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_i),
        .enable (arb_en),
        .gnt    (gnt)
    );

    // Validation of the request that would be granted this cycle; the sum is 33 bits so it cannot wrap.
    always_comb begin
        sel       = gnt[1];
        sel_addr  = addr_i[sel];
        sel_ctrl  = ctrl_i[sel];
        last_byte = {1'b0, sel_addr} + {30'd0, access_bytes(dmctrl_t'(sel_ctrl))} - 33'd1;
`ifdef DMEM_ACCESS_ALIGN_CHECK_EN
        misalign  = (((sel_ctrl == DM_H) || (sel_ctrl == DM_HU)) && sel_addr[0]) ||
                    ((sel_ctrl == DM_W) && (sel_addr[1:0] != 2'b00));
`else
        misalign  = 1'b0;
`endif
        sel_bad   = !ctrl_legal(sel_ctrl) ||
                    (wr_i[sel] && ((sel_ctrl == DM_BU) || (sel_ctrl == DM_HU))) ||
                    (last_byte >= MEM_LIMIT) ||
                    misalign;
    end

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        ctrl_d  = ctrl_q;
        bad_d   = bad_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    state_d = ST_ACCESS;
                    port_d  = sel;
                    addr_d  = sel_addr;
                    wdata_d = wdata_i[sel];
                    wr_d    = wr_i[sel];
                    ctrl_d  = sel_ctrl;
                    bad_d   = sel_bad;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                rdata_d = (bad_q || wr_q) ? 32'd0 : mem_rdata_i;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            port_q  <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
            ctrl_q  <= 3'b000;
            bad_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            ctrl_q  <= ctrl_d;
            bad_q   <= bad_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory port is only driven during ACCESS; reset kills an in-flight store immediately.
    always_comb begin
        gnt_o       = gnt;
        rdata_o     = rdata_q;
        mem_addr_o  = 32'd0;
        mem_wdata_o = 32'd0;
        mem_ctrl_o  = 3'b000;
        mem_wr_o    = 1'b0;
        rvalid_o    = 2'b00;
        err_o       = 1'b0;
        if (state_q == ST_ACCESS) begin
            mem_addr_o  = addr_q;
            mem_wdata_o = wdata_q;
            mem_ctrl_o  = ctrl_q;
            mem_wr_o    = wr_q && !bad_q && !rst;
        end
        if ((state_q == ST_RESP) && !rst) begin
            rvalid_o = port_q ? 2'b10 : 2'b01;
            err_o    = bad_q;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: a table of single-port transactions plus
// hand-written sequences for arbitration conflicts and reset in ACCESS/RESP.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_i;
    logic [31:0] addr_i  [2];
    logic [31:0] wdata_i [2];
    logic [1:0]  wr_i;
    logic [2:0]  ctrl_i  [2];
    logic [1:0]  gnt_o;
    logic [1:0]  rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_wr_o;
    logic [2:0]  mem_ctrl_o;
    logic [31:0] mem_rdata_i;

    logic [7:0]  mem [1024];
    logic [7:0]  rb  [4];
    logic [31:0] ba;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic        port;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic [2:0]  ctrl;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    dmem_access_ctrl #(.MEM_SIZE(1024)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .wr_i        (wr_i),
        .ctrl_i      (ctrl_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wr_o    (mem_wr_o),
        .mem_ctrl_o  (mem_ctrl_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Byte-addressed little-endian memory: combinational read with DMCtrl extension, out-of-range bytes read as 0.
    always_comb begin
        ba = 32'd0;
        for (int k = 0; k < 4; k++) begin
            ba    = mem_addr_o + 32'(k);
            rb[k] = (ba < 32'd1024) ? mem[ba[9:0]] : 8'h00;
        end
        case (mem_ctrl_o)
            3'b000:  mem_rdata_i = {{24{rb[0][7]}}, rb[0]};
            3'b001:  mem_rdata_i = {{16{rb[1][7]}}, rb[1], rb[0]};
            3'b010:  mem_rdata_i = {rb[3], rb[2], rb[1], rb[0]};
            3'b100:  mem_rdata_i = {24'd0, rb[0]};
            3'b101:  mem_rdata_i = {16'd0, rb[1], rb[0]};
            default: mem_rdata_i = 32'd0;
        endcase
    end

    // Synchronous memory write driven by the DUT's memory port.
    always @(posedge clk) begin
        if (mem_wr_o && (mem_addr_o < 32'd1021)) begin
            mem[mem_addr_o[9:0]] <= mem_wdata_o[7:0];
            if (mem_ctrl_o != 3'b000) mem[mem_addr_o[9:0] + 10'd1] <= mem_wdata_o[15:8];
            if (mem_ctrl_o == 3'b010) begin
                mem[mem_addr_o[9:0] + 10'd2] <= mem_wdata_o[23:16];
                mem[mem_addr_o[9:0] + 10'd3] <= mem_wdata_o[31:24];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Runs one single-port transaction starting just after a rising edge with the DUT in IDLE.
    task automatic applyStimulus(input vec_t v);
        logic [1:0] oh;
        oh = v.port ? 2'b10 : 2'b01;
        addr_i[v.port]  = v.addr;
        wdata_i[v.port] = v.wdata;
        wr_i[v.port]    = v.wr;
        ctrl_i[v.port]  = v.ctrl;
        req_i[v.port]   = 1'b1;
        @(negedge clk);
        checkOutput({v.name, " gnt"}, {30'd0, gnt_o}, {30'd0, oh});
        @(posedge clk); #1;
        req_i = 2'b00;
        @(negedge clk);
        checkOutput({v.name, " mem_wr"}, {31'd0, mem_wr_o}, {31'd0, v.wr && !v.exp_err});
        checkOutput({v.name, " mem_addr"}, mem_addr_o, v.addr);
        @(posedge clk);
        @(negedge clk);
        checkOutput({v.name, " rvalid"}, {30'd0, rvalid_o}, {30'd0, oh});
        checkOutput({v.name, " rdata"}, rdata_o, v.exp_rdata);
        checkOutput({v.name, " err"}, {31'd0, err_o}, {31'd0, v.exp_err});
        @(posedge clk); #1;
    endtask

    logic [1:0] exp_gnt [12];
    logic [1:0] exp_rv  [12];

    initial begin
        logic [1:0] g;
        int pend0;
        int pend1;

        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[16'h10] = 8'h11; mem[16'h11] = 8'h22; mem[16'h12] = 8'h33; mem[16'h13] = 8'h44;
        mem[16'h80] = 8'h80;
        mem[16'h21] = 8'hA1; mem[16'h22] = 8'hB2; mem[16'h23] = 8'hC3; mem[16'h24] = 8'hD4;
        mem[16'h3FC] = 8'h01; mem[16'h3FD] = 8'h02; mem[16'h3FE] = 8'h03; mem[16'h3FF] = 8'h04;

        vecs[0]  = '{"ld_w_10",      1'b0, 32'h10,       32'h0,        1'b0, 3'b010, 32'h44332211, 1'b0};
        vecs[1]  = '{"st_b_60",      1'b0, 32'h60,       32'h000000A5, 1'b1, 3'b000, 32'h0,        1'b0};
        vecs[2]  = '{"ld_bu_60",     1'b0, 32'h60,       32'h0,        1'b0, 3'b100, 32'h000000A5, 1'b0};
        vecs[3]  = '{"st_w_3fe",     1'b1, 32'h3FE,      32'hDEADBEEF, 1'b1, 3'b010, 32'h0,        1'b1};
        vecs[4]  = '{"st_hu",        1'b0, 32'h40,       32'h12345678, 1'b1, 3'b101, 32'h0,        1'b1};
        vecs[5]  = '{"ld_ctrl011",   1'b0, 32'h40,       32'h0,        1'b0, 3'b011, 32'h0,        1'b1};
        vecs[6]  = '{"ld_b_80",      1'b0, 32'h80,       32'h0,        1'b0, 3'b000, 32'hFFFFFF80, 1'b0};
        vecs[7]  = '{"ld_bu_80",     1'b0, 32'h80,       32'h0,        1'b0, 3'b100, 32'h00000080, 1'b0};
        vecs[8]  = '{"st_h_50",      1'b1, 32'h50,       32'h1234BEEF, 1'b1, 3'b001, 32'h0,        1'b0};
        vecs[9]  = '{"ld_hu_50",     1'b1, 32'h50,       32'h0,        1'b0, 3'b101, 32'h0000BEEF, 1'b0};
        vecs[10] = '{"ld_h_50",      1'b1, 32'h50,       32'h0,        1'b0, 3'b001, 32'hFFFFBEEF, 1'b0};
        vecs[11] = '{"ld_w_3fc",     1'b0, 32'h3FC,      32'h0,        1'b0, 3'b010, 32'h04030201, 1'b0};
        vecs[12] = '{"ld_b_400",     1'b0, 32'h400,      32'h0,        1'b0, 3'b000, 32'h0,        1'b1};
        vecs[13] = '{"ld_w_3fd",     1'b0, 32'h3FD,      32'h0,        1'b0, 3'b010, 32'h0,        1'b1};
        vecs[14] = '{"ld_w_nowrap",  1'b0, 32'hFFFFFFFF, 32'h0,        1'b0, 3'b010, 32'h0,        1'b1};
`ifdef DMEM_ACCESS_ALIGN_CHECK_EN
        vecs[15] = '{"ld_w_21",      1'b1, 32'h21,       32'h0,        1'b0, 3'b010, 32'h0,        1'b1};
`else
        vecs[15] = '{"ld_w_21",      1'b1, 32'h21,       32'h0,        1'b0, 3'b010, 32'hD4C3B2A1, 1'b0};
`endif

        for (int c = 0; c < 12; c++) begin
            exp_gnt[c] = 2'b00;
            exp_rv[c]  = 2'b00;
        end
        exp_gnt[0] = 2'b01; exp_gnt[3] = 2'b10; exp_gnt[6] = 2'b01; exp_gnt[9]  = 2'b10;
        exp_rv[2]  = 2'b01; exp_rv[5]  = 2'b10; exp_rv[8]  = 2'b01; exp_rv[11] = 2'b10;

        rst   = 1'b1;
        req_i = 2'b00;
        wr_i  = 2'b00;
        for (int p = 0; p < 2; p++) begin
            addr_i[p]  = 32'd0;
            wdata_i[p] = 32'd0;
            ctrl_i[p]  = 3'b000;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst gnt",       {30'd0, gnt_o},    32'd0);
        checkOutput("rst rvalid",    {30'd0, rvalid_o}, 32'd0);
        checkOutput("rst rdata",     rdata_o,           32'd0);
        checkOutput("rst err",       {31'd0, err_o},    32'd0);
        checkOutput("rst mem_wr",    {31'd0, mem_wr_o}, 32'd0);
        checkOutput("rst mem_addr",  mem_addr_o,        32'd0);
        checkOutput("rst mem_wdata", mem_wdata_o,       32'd0);
        checkOutput("rst mem_ctrl",  {29'd0, mem_ctrl_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Both ports want two word loads each: grants alternate 0,1,0,1 every third cycle.
        for (int p = 0; p < 2; p++) begin
            addr_i[p] = 32'h10;
            ctrl_i[p] = 3'b010;
        end
        pend0 = 2;
        pend1 = 2;
        req_i = 2'b11;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checkOutput($sformatf("conflict gnt c%0d", c), {30'd0, gnt_o}, {30'd0, exp_gnt[c]});
            checkOutput($sformatf("conflict rvalid c%0d", c), {30'd0, rvalid_o}, {30'd0, exp_rv[c]});
            if (exp_rv[c] != 2'b00) checkOutput($sformatf("conflict rdata c%0d", c), rdata_o, 32'h44332211);
            g = gnt_o;
            @(posedge clk); #1;
            if (g[0]) begin
                pend0--;
                if (pend0 == 0) req_i[0] = 1'b0;
            end
            if (g[1]) begin
                pend1--;
                if (pend1 == 0) req_i[1] = 1'b0;
            end
        end

        for (int i = 0; i < 16; i++) applyStimulus(vecs[i]);

        // Reset in RESP: the response strobe is suppressed.
        addr_i[1] = 32'h10; ctrl_i[1] = 3'b010; wr_i[1] = 1'b0; req_i[1] = 1'b1;
        @(negedge clk);
        checkOutput("rstresp gnt", {30'd0, gnt_o}, 32'd2);
        @(posedge clk); #1;
        req_i = 2'b00;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstresp rvalid", {30'd0, rvalid_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset in ACCESS of a port-0 store: no write, no rvalid, and last_grant returns to 1.
        addr_i[0] = 32'h20; wdata_i[0] = 32'h000000A5; ctrl_i[0] = 3'b000; wr_i[0] = 1'b1; req_i[0] = 1'b1;
        @(negedge clk);
        checkOutput("rstacc gnt", {30'd0, gnt_o}, 32'd1);
        @(posedge clk); #1;
        req_i = 2'b00;
        rst   = 1'b1;
        @(negedge clk);
        checkOutput("rstacc mem_wr", {31'd0, mem_wr_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstacc rvalid", {30'd0, rvalid_o}, 32'd0);
        checkOutput("rstacc byte20", {24'd0, mem[16'h20]}, 32'd0);
        @(posedge clk); #1;
        wr_i  = 2'b00;
        ctrl_i[0] = 3'b100;
        ctrl_i[1] = 3'b100;
        addr_i[1] = 32'h20;
        req_i = 2'b11;
        @(negedge clk);
        checkOutput("post-rst conflict gnt", {30'd0, gnt_o}, 32'd1);
        @(posedge clk); #1;
        req_i[0] = 1'b0;
        @(negedge clk);
        checkOutput("busy ignores req", {30'd0, gnt_o}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("post-rst rvalid", {30'd0, rvalid_o}, 32'd1);
        checkOutput("post-rst byte20", rdata_o, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("loser gnt", {30'd0, gnt_o}, 32'd2);
        @(posedge clk); #1;
        req_i = 2'b00;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequential access controller placed in front of the byte-addressed data memory of the RV32I core. It shares the memory's single port between two requesters: port 0 is the core's load/store path and port 1 is the program loader/debug path. It uses round-robin arbitration and a three-phase grant/access/response sequence. It validates each request's DMCtrl encoding and address range before driving the memory's Address/DataWr/DMWr/DMCtrl inputs, and returns registered read data with an error flag.

## Interface
- MEM_SIZE, 1024: memory size in bytes; used for the range check.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_i[2]  in  1 each  request from port p; held until gnt_o[p].
- addr_i[2]  in  32 each  byte address.
- wdata_i[2]  in  32 each  store data, little-endian low bytes used.
- wr_i[2]  in  1 each  1 = store, 0 = load.
- ctrl_i[2]  in  3 each  DMCtrl: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
- gnt_o[2]  out  1 each  request accepted this cycle.
- rvalid_o[2]  out  1 each  one-cycle response strobe.
- rdata_o  out  32  load result, valid with rvalid_o; shared by both ports.
- err_o  out  1  error flag, valid with rvalid_o.
- mem_addr_o  out  32  to memory Address.
- mem_wdata_o  out  32  to memory DataWr.
- mem_wr_o  out  1  to memory DMWr.
- mem_ctrl_o  out  3  to memory DMCtrl.
- mem_rdata_i  in  32  from memory DataRd; combinational.

## Operation
- States: IDLE, ACCESS, RESP.
  - IDLE -> ACCESS when any req_i is high.
  - ACCESS -> RESP unconditionally.
  - RESP -> IDLE unconditionally.
- Grant in IDLE, combinationally in the same cycle as the requests:
  - Single requester: that requester is granted.
  - Both requesting: the port that was not last granted wins.
  - last_grant updates on each grant.
- The winner's address, data, write flag, control and port id are latched at the grant edge.
- Requests arriving outside IDLE are ignored with no gnt_o. The requester keeps req_i high and is serviced later.
- Check at grant, result latched as a bad flag:
  - ctrl is not one of the five legal codes, or
  - wr=1 with ctrl 100 or 101, or
  - addr + nbytes - 1 >= MEM_SIZE, where nbytes is 1, 2 or 4; compute this sum 33 bits wide, no wrap.
- ACCESS cycle:
  - mem_addr_o, mem_wdata_o and mem_ctrl_o are driven from the latched request.
  - mem_wr_o = latched wr & ~bad & ~rst.
  - mem_rdata_i is captured into the rdata register, or 0 if bad or if the access is a store.
- RESP cycle:
  - rvalid_o[latched port] = 1.
  - err_o = bad.
  - rdata_o holds the captured value.
- Outside ACCESS: mem_wr_o=0, mem_addr_o=0, mem_wdata_o=0, mem_ctrl_o=000.

## Timing
- Reset values:
  - state IDLE, last_grant=1 (port 0 wins the first conflict).
  - gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0.
  - mem_wr_o=0, mem_addr_o=0, mem_wdata_o=0, mem_ctrl_o=000.
- Latency: gnt in cycle N, memory access in N+1, rvalid in N+2. The next grant is possible in N+3, so maximum throughput is one access per 3 cycles.
- Simultaneous req_i in IDLE: exactly one gnt_o is asserted; the loser is granted in the next IDLE cycle if it is still requesting.
- Reset asserted during ACCESS:
  - the store is suppressed (mem_wr_o forced 0);
  - no rvalid is issued;
  - state returns to IDLE next cycle.
- Reset asserted during RESP: rvalid_o is forced 0 in that cycle.
- A rejected request (bad) still takes the full 3 cycles and still updates last_grant.

## Configuration
- DMEM_ACCESS_ALIGN_CHECK_EN:
  - Defined: the bad check also includes a misaligned half (addr[0]=1) or a misaligned word (addr[1:0]!=0). Such requests get err_o=1, no memory write, rdata 0.
  - Undefined: misaligned accesses pass through to memory unchanged, and err_o reflects only the encoding and range checks.

## Structure
- Package dmem_pkg:
  - dmctrl_t enum (DM_B, DM_H, DM_W, DM_BU, DM_HU);
  - dmem_state_t enum;
  - function access_bytes(dmctrl_t) returning 1, 2 or 4;
  - function ctrl_legal.
- Sub-module rr_arb2: 2-input round-robin arbiter holding the last_grant register, with inputs req[2] and enable, and output gnt[2].

## Test plan
- Port 0 word load from addr 0x10 with memory bytes 0x10..0x13 = 11 22 33 44 -> gnt_o[0] in cycle 0; rvalid_o[0] in cycle 2 with rdata_o=0x44332211, err_o=0.
- Both ports request in the same cycle, held for two transactions -> first service on port 0, second on port 1 (gnt cycles 0 and 3), then port 0 again.
- Port 1 store, ctrl=010, addr 0x3FE, MEM_SIZE=1024 -> mem_wr_o stays 0; rvalid_o[1] with err_o=1, rdata_o=0.
- Port 0 store with ctrl=101, then a load with ctrl=011 -> both give err_o=1 with no memory write; a following legal byte load of 0x80 returns 0xFFFFFF80.
- Reset asserted in the ACCESS cycle of a store of 0xA5 to addr 0x20 -> memory byte 0x20 unchanged, no rvalid, state IDLE; the next conflict grants port 0.
- With DMEM_ACCESS_ALIGN_CHECK_EN defined, a word load at addr 0x21 -> err_o=1. Without the macro, the same load -> err_o=0 and rdata is the data at 0x21..0x24.
